// File: rtl/rv_rtype_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rv_rtype_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the
//               RV32I R-type datapath. Fetches over a req/ack port, checks
//               R-type legality, drives the register file and ALU, writes
//               back and advances the PC. Illegal encodings lock into TRAP.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_rtype_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [24:0] dec_instr,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  dec_alu_control,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        busy,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DECODE    = 3'd2;
    localparam logic [2:0] EXECUTE   = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] TRAP      = 3'd5;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    logic [2:0]  state;
    logic [31:0] pc_reg;
    logic [31:0] retired_reg;
    logic        illegal_reg;
    logic [31:0] instr_reg;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic [4:0]  rd_reg;
    logic [4:0]  op_reg;
    logic [31:0] opa_reg;
    logic [31:0] opb_reg;
    logic [31:0] result_reg;
    logic        instr_valid;

    // Legal R-type: OP opcode, funct7 zero, or 0x20 only for SUB/SRA
    always_comb begin
        instr_valid = 1'b0;
        if (instr_reg[6:0] == OPCODE_OP) begin
            if (instr_reg[31:25] == 7'h00) begin
                instr_valid = 1'b1;
            end else if (instr_reg[31:25] == 7'h20 &&
                         (instr_reg[14:12] == 3'd0 || instr_reg[14:12] == 3'd5)) begin
                instr_valid = 1'b1;
            end
        end
    end

    // Sequencer state and all architectural/pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_reg      <= RESET_PC;
            retired_reg <= 32'd0;
            illegal_reg <= 1'b0;
            instr_reg   <= 32'd0;
            rs1_reg     <= 5'd0;
            rs2_reg     <= 5'd0;
            rd_reg      <= 5'd0;
            op_reg      <= 5'd0;
            opa_reg     <= 32'd0;
            opb_reg     <= 32'd0;
            result_reg  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (instr_valid) begin
                        rs1_reg <= dec_rs1;
                        rs2_reg <= dec_rs2;
                        rd_reg  <= dec_rd;
                        op_reg  <= dec_alu_control;
                        state   <= EXECUTE;
                    end else begin
                        illegal_reg <= 1'b1;
                        state       <= TRAP;
                    end
                end
                EXECUTE: begin
                    // Operands are kept so alu_a/alu_b hold after EXECUTE
                    opa_reg    <= rf_rdata1;
                    opb_reg    <= rf_rdata2;
                    result_reg <= alu_result;
                    state      <= WRITEBACK;
                end
                WRITEBACK: begin
                    pc_reg      <= pc_reg + 32'd4;
                    retired_reg <= retired_reg + 32'd1;
                    state       <= run ? FETCH : IDLE;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; ALU operands pass through live only while executing
    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = pc_reg;
        dec_instr = instr_reg[31:7];
        rf_raddr1 = rs1_reg;
        rf_raddr2 = rs2_reg;
        alu_a     = (state == EXECUTE) ? rf_rdata1 : opa_reg;
        alu_b     = (state == EXECUTE) ? rf_rdata2 : opb_reg;
        alu_op    = op_reg;
        rf_we     = (state == WRITEBACK) && (rd_reg != 5'd0);
        rf_waddr  = rd_reg;
        rf_wdata  = result_reg;
        pc        = pc_reg;
        busy      = (state != IDLE) && (state != TRAP);
        illegal   = illegal_reg;
        retired   = retired_reg;
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_rtype_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_rtype_sequencer
// Description : Self-checking bench: table vectors, randomized R-type stream
//               against an instruction-level model, trap/reset/wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_rtype_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [24:0] dec_instr;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, dec_alu_control;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        busy;
    logic        illegal;
    logic [31:0] retired;

    // second instance with a PC close to the top of the address space
    logic        w_rst_n, w_run, w_imem_req, w_imem_ack, w_rf_we, w_busy, w_illegal;
    logic [31:0] w_imem_addr, w_imem_rdata, w_rf_rdata1, w_rf_rdata2;
    logic [31:0] w_alu_a, w_alu_b, w_alu_result, w_rf_wdata, w_pc, w_retired;
    logic [24:0] w_dec_instr;
    logic [4:0]  w_dec_rs1, w_dec_rs2, w_dec_rd, w_dec_alu_control;
    logic [4:0]  w_rf_raddr1, w_rf_raddr2, w_alu_op, w_rf_waddr;

    logic [31:0] rf     [32];
    logic [31:0] ref_rf [32];
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    int          vectors;
    int          miscompares;

    rv_rtype_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dec_instr(dec_instr), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_alu_control(dec_alu_control),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .busy(busy), .illegal(illegal), .retired(retired)
    );

    rv_rtype_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .run(w_run),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack),
        .imem_rdata(w_imem_rdata),
        .dec_instr(w_dec_instr), .dec_rs1(w_dec_rs1), .dec_rs2(w_dec_rs2), .dec_rd(w_dec_rd),
        .dec_alu_control(w_dec_alu_control),
        .rf_raddr1(w_rf_raddr1), .rf_raddr2(w_rf_raddr2),
        .rf_rdata1(w_rf_rdata1), .rf_rdata2(w_rf_rdata2),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op), .alu_result(w_alu_result),
        .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
        .pc(w_pc), .busy(w_busy), .illegal(w_illegal), .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU, keyed by the decoder code {0, instr[30], funct3}
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd8:    return a + ~b + 32'd1;
            5'd1:    return a << b[4:0];
            5'd2:    return {31'd0, $signed(a) < $signed(b)};
            5'd3:    return {31'd0, a < b};
            5'd4:    return a ^ b;
            5'd5:    return a >> b[4:0];
            5'd13:   return 32'($signed(a) >>> b[4:0]);
            5'd6:    return a | b;
            5'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Environment decoder
    assign dec_rd            = dec_instr[4:0];
    assign dec_rs1           = dec_instr[12:8];
    assign dec_rs2           = dec_instr[17:13];
    assign dec_alu_control   = {1'b0, dec_instr[23], dec_instr[7:5]};
    assign w_dec_rd          = w_dec_instr[4:0];
    assign w_dec_rs1         = w_dec_instr[12:8];
    assign w_dec_rs2         = w_dec_instr[17:13];
    assign w_dec_alu_control = {1'b0, w_dec_instr[23], w_dec_instr[7:5]};
    assign rf_rdata1         = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
    assign rf_rdata2         = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];
    assign w_rf_rdata1       = (w_rf_raddr1 == 5'd0) ? 32'd0 : rf[w_rf_raddr1];
    assign w_rf_rdata2       = (w_rf_raddr2 == 5'd0) ? 32'd0 : rf[w_rf_raddr2];
    assign alu_result        = alu_fn(alu_op, alu_a, alu_b);
    assign w_alu_result      = alu_fn(w_alu_op, w_alu_a, w_alu_b);

    // Register file write port (only the main instance writes)
    always @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
    end

    // Instruction-level reference: result from the RV32I meaning of the word
    function automatic logic [31:0] ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
        int unsigned sh;
        logic        alt;
        sh  = int'(b % 32);
        alt = (ins[31:25] == 7'h20);
        case (ins[14:12])
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Run one instruction through fetch..writeback, checking every cycle
    task automatic do_instr(input logic [31:0] ins, input int dly, input logic drop,
                            output logic got_we, output logic [31:0] got_wdata,
                            output logic trapped);
        int          waited;
        logic [4:0]  rs1, rs2, rd;
        logic        valid;
        logic [31:0] expv;
        waited = 0; trapped = 1'b0; got_we = 1'b0; got_wdata = 32'd0;
        while (imem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        if (imem_req !== 1'b1) return;
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < dly; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            tick();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, exp_pc);
        end
        imem_ack = 1'b1; imem_rdata = ins;
        tick();
        imem_ack = 1'b0; imem_rdata = $urandom;
        check("dec_instr", 32'(dec_instr), 32'(ins[31:7]));
        check("dec_busy", 32'(busy), 32'd1);
        check("dec_req", 32'(imem_req), 32'd0);
        rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
        valid = (ins[6:0] == 7'h33) && ((ins[31:25] == 7'h00) ||
                (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5)));
        if (!valid) begin
            tick();
            check("trap_illegal", 32'(illegal), 32'd1);
            check("trap_busy", 32'(busy), 32'd0);
            check("trap_pc", pc, exp_pc);
            check("trap_retired", retired, exp_ret);
            trapped = 1'b1;
            return;
        end
        tick();
        check("ex_alu_a", alu_a, ref_rf[rs1]);
        check("ex_alu_b", alu_b, ref_rf[rs2]);
        check("ex_alu_op", 32'(alu_op), 32'({1'b0, ins[30], ins[14:12]}));
        check("ex_we", 32'(rf_we), 32'd0);
        expv = ref_exec(ins, ref_rf[rs1], ref_rf[rs2]);
        if (drop) run = 1'b0;
        tick();
        got_we = rf_we; got_wdata = rf_wdata;
        check("wb_we", 32'(rf_we), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            check("wb_waddr", 32'(rf_waddr), 32'(rd));
            check("wb_wdata", rf_wdata, expv);
            ref_rf[rd] = expv;
        end
        tick();
        exp_pc  = exp_pc + 32'd4;
        exp_ret = exp_ret + 32'd1;
        check("post_pc", pc, exp_pc);
        check("post_retired", retired, exp_ret);
        check("post_we", 32'(rf_we), 32'd0);
        if (run) begin
            check("post_req", 32'(imem_req), 32'd1);
            check("post_addr", imem_addr, exp_pc);
        end else begin
            check("post_busy", 32'(busy), 32'd0);
            check("post_req_idle", 32'(imem_req), 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        int          dly;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vecs [7];
    logic        g_we, g_trap;
    logic [31:0] g_wdata;
    logic [31:0] rins;
    logic [2:0]  f3;
    logic [6:0]  f7;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        w_rst_n = 1'b0; w_run = 1'b0; w_imem_ack = 1'b0; w_imem_rdata = 32'd0;
        rf[0] = 32'd0; ref_rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            rf[i] = $urandom; ref_rf[i] = rf[i];
        end
        rf[1] = 32'd5; ref_rf[1] = 32'd5;
        rf[2] = 32'd7; ref_rf[2] = 32'd7;
        exp_pc = 32'd0; exp_ret = 32'd0;

        vecs[0] = '{32'h002081B3, 0, 1'b1, 32'd12};          // add x3,x1,x2
        vecs[1] = '{32'h402081B3, 0, 1'b1, 32'hFFFF_FFFE};   // sub x3,x1,x2
        vecs[2] = '{32'h00208033, 3, 1'b0, 32'd0};           // add x0: no write, 7-cycle latency
        vecs[3] = '{32'h0020E233, 1, 1'b1, 32'd7};           // or  x4,x1,x2
        vecs[4] = '{32'h0020F2B3, 0, 1'b1, 32'd5};           // and x5,x1,x2
        vecs[5] = '{32'h4011D333, 2, 1'b1, 32'hFFFF_FFFF};   // sra x6,x3,x1
        vecs[6] = '{32'h0011A3B3, 0, 1'b1, 32'd1};           // slt x7,x3,x1

        // reset state
        tick(); tick();
        check("rst_pc", pc, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_dec", 32'(dec_instr), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        tick();

        // ack in IDLE must be ignored
        imem_ack = 1'b1; imem_rdata = 32'h002081B3;
        tick(); tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_req", 32'(imem_req), 32'd0);
        check("idle_dec", 32'(dec_instr), 32'd0);
        imem_ack = 1'b0;
        run = 1'b1;

        foreach (vecs[k]) begin
            do_instr(vecs[k].instr, vecs[k].dly, 1'b0, g_we, g_wdata, g_trap);
            check("tbl_we", 32'(g_we), 32'(vecs[k].exp_we));
            if (vecs[k].exp_we) check("tbl_wdata", g_wdata, vecs[k].exp_wdata);
        end

        // run dropped mid-EXECUTE: instruction still retires, then IDLE
        do_instr(32'h002081B3, 3, 1'b1, g_we, g_wdata, g_trap);
        tick(); tick();
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_req", 32'(imem_req), 32'd0);
        check("drop_retired", retired, exp_ret);
        run = 1'b1;

        // randomized legal R-type stream
        for (int n = 0; n < 30; n++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            rins = {f7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3,
                    5'($urandom_range(0, 31)), 7'h33};
            do_instr(rins, int'($urandom_range(0, 2)), 1'b0, g_we, g_wdata, g_trap);
        end

        // illegal opcode: trap absorbs, acks ignored, no requests
        do_instr(32'h00000013, 0, 1'b0, g_we, g_wdata, g_trap);
        check("addi_trapped", 32'(g_trap), 32'd1);
        for (int n = 0; n < 20; n++) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 32'h002081B3;
            tick();
            check("trap_hold_req", 32'(imem_req), 32'd0);
            check("trap_hold_we", 32'(rf_we), 32'd0);
            check("trap_hold_busy", 32'(busy), 32'd0);
            check("trap_hold_pc", pc, exp_pc);
        end
        imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        check("trap_rst_pc", pc, 32'd0);
        check("trap_rst_retired", retired, 32'd0);
        exp_pc = 32'd0; exp_ret = 32'd0;
        tick();
        rst_n = 1'b1;

        // illegal funct7 (0x20 with funct3=1)
        do_instr(32'h402091B3, 0, 1'b0, g_we, g_wdata, g_trap);
        check("f7_trapped", 32'(g_trap), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // ack coinciding with reset: reset wins
        for (int n = 0; n < 20 && imem_req !== 1'b1; n++) tick();
        check("sim_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h002081B3; rst_n = 1'b0;
        tick();
        check("sim_dec", 32'(dec_instr), 32'd0);
        check("sim_busy", 32'(busy), 32'd0);
        imem_ack = 1'b0; rst_n = 1'b1;

        // PC wrap instance
        tick();
        w_rst_n = 1'b1; w_run = 1'b1;
        tick();
        check("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        w_imem_ack = 1'b1; w_imem_rdata = 32'h002081B3;
        tick();
        w_imem_ack = 1'b0;
        tick(); tick();
        check("wrap_we", 32'(w_rf_we), 32'd1);
        check("wrap_wdata", w_rf_wdata, ref_rf[1] + ref_rf[2]);
        tick();
        check("wrap_pc", w_pc, 32'd0);
        check("wrap_retired", w_retired, 32'd1);
        w_imem_ack = 1'b1;
        tick();
        w_imem_ack = 1'b0;
        tick();
        check("wrap_ex_busy", 32'(w_busy), 32'd1);
        #2 w_rst_n = 1'b0;
        #1;
        check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_rst_retired", w_retired, 32'd0);
        check("wrap_rst_busy", 32'(w_busy), 32'd0);
        check("wrap_rst_req", 32'(w_imem_req), 32'd0);
        check("wrap_rst_we", 32'(w_rf_we), 32'd0);
        check("wrap_rst_dec", 32'(w_dec_instr), 32'd0);
        check("wrap_rst_alu_a", w_alu_a, 32'd0);
        check("wrap_rst_alu_b", w_alu_b, 32'd0);
        check("wrap_rst_alu_op", 32'(w_alu_op), 32'd0);
        check("wrap_rst_raddr1", 32'(w_rf_raddr1), 32'd0);
        check("wrap_rst_waddr", 32'(w_rf_waddr), 32'd0);
        check("wrap_rst_wdata", w_rf_wdata, 32'd0);
        check("wrap_rst_illegal", 32'(w_illegal), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
